// File: rtl/apb_master.sv
// apb_master: turns one-cycle CPU requests into APB SETUP/ACCESS transfers across five decoded slave slots
module apb_master #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int SLOT_SHIFT = 12
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        transfer,
   input  logic        write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   output logic        PWRITE,
   output logic        PENABLE,
   output logic        PSEL0,
   output logic        PSEL1,
   output logic        PSEL2,
   output logic        PSEL3,
   output logic        PSEL4,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic [31:0] PRDATA4,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3,
   input  logic        PREADY4
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state, state_nx;
   logic [31:0] addr_r, wdata_r, offset, slot, p_rdata;
   logic [31:0] prdata [5];
   logic [4:0] sel_vec, pready;
   logic write_r, valid, p_ready, active;
   assign prdata = '{PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4};
   assign pready = {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0};
   assign offset = addr_r - BASE_ADDR;
   assign slot = offset >> SLOT_SHIFT;
   assign valid = addr_r >= BASE_ADDR && offset < (32'd5 << SLOT_SHIFT);
   for (genvar g = 0; g < 5; g++) begin : g_sel
      assign sel_vec[g] = valid && slot == 32'(g);
   end
   // unmapped addresses complete immediately with zero data instead of hanging
   always_comb begin
      p_rdata = '0;
      p_ready = ~|sel_vec;
      for (int i = 0; i < 5; i++)
         if (sel_vec[i]) begin
            p_rdata = prdata[i];
            p_ready = pready[i];
         end
   end
   always_comb
      state_nx = state == IDLE  ? (transfer ? SETUP : IDLE) :
                 state == SETUP ? ACCESS :
                 (p_ready ? IDLE : ACCESS);
   always_ff @(posedge PCLK or posedge PRESET)
      if (PRESET) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge PCLK or posedge PRESET)
      if (PRESET) begin
         addr_r  <= '0;
         wdata_r <= '0;
         write_r <= 1'b0;
      end else if (state == IDLE && transfer) begin
         addr_r  <= addr;
         wdata_r <= wdata;
         write_r <= write;
      end
   assign active = state != IDLE;
   assign {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0} = sel_vec & {5{active}};
   assign PENABLE = state == ACCESS;
   assign ready = PENABLE && p_ready;
   assign rdata = (ready && !write_r) ? p_rdata : '0;
   assign PADDR = addr_r;
   assign PWDATA = wdata_r;
   assign PWRITE = write_r;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed APB transfers with hand-computed expectations
module tb_apb_master;
   logic PCLK, PRESET, transfer, write, ready, PWRITE, PENABLE;
   logic [31:0] addr, wdata, rdata, PADDR, PWDATA;
   logic PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
   logic PREADY0, PREADY1, PREADY2, PREADY3, PREADY4;
   logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4;
   logic [4:0] psel;
   int checks = 0, errors = 0;
   assign psel = {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};
   apb_master dut (
      .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
      .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4),
      .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3), .PRDATA4(PRDATA4),
      .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3), .PREADY4(PREADY4)
   );
   initial begin
      PCLK = 0;
      forever #5 PCLK = ~PCLK;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask
   task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d);
      transfer = 1; write = w; addr = a; wdata = d;
      tick;
      transfer = 0; write = ~w; addr = 32'hDEAD_BEEF; wdata = 32'h0BAD_0BAD;
   endtask
   task automatic all_zero(input string tag);
      chk({tag, "_paddr"}, PADDR, 0);
      chk({tag, "_pwdata"}, PWDATA, 0);
      chk({tag, "_pwrite"}, {31'b0, PWRITE}, 0);
      chk({tag, "_penable"}, {31'b0, PENABLE}, 0);
      chk({tag, "_psel"}, {27'b0, psel}, 0);
      chk({tag, "_ready"}, {31'b0, ready}, 0);
      chk({tag, "_rdata"}, rdata, 0);
   endtask
   initial begin
      logic [31:0] unm [3];
      unm = '{32'h2000_0000, 32'h1000_5000, 32'h0FFF_FFFC};
      PRESET = 1; transfer = 0; write = 0; addr = 0; wdata = 0;
      {PREADY0, PREADY1, PREADY2, PREADY3, PREADY4} = '0;
      PRDATA0 = 0; PRDATA1 = 0; PRDATA2 = 0; PRDATA3 = 0; PRDATA4 = 0;
      #2;
      all_zero("rst");
      tick;
      PRESET = 0;
      tick;
      // write slot 3, zero-wait
      PREADY3 = 1;
      req(1, 32'h1000_3000, 32'h0000_00FF);
      #1;
      chk("w_s_psel", {27'b0, psel}, 5'b01000);
      chk("w_s_pen", {31'b0, PENABLE}, 0);
      chk("w_s_paddr", PADDR, 32'h1000_3000);
      chk("w_s_pwdata", PWDATA, 32'hFF);
      chk("w_s_pwrite", {31'b0, PWRITE}, 1);
      chk("w_s_ready", {31'b0, ready}, 0);
      tick;
      chk("w_a_pen", {31'b0, PENABLE}, 1);
      chk("w_a_psel", {27'b0, psel}, 5'b01000);
      chk("w_a_ready", {31'b0, ready}, 1);
      chk("w_a_rdata", rdata, 0);
      tick;
      chk("w_i_psel", {27'b0, psel}, 0);
      chk("w_i_ready", {31'b0, ready}, 0);
      // read slot 3, registered PREADY
      PREADY3 = 0; PRDATA3 = 32'hA5;
      req(0, 32'h1000_3004, 0);
      #1;
      chk("r3_s_psel", {27'b0, psel}, 5'b01000);
      tick;
      chk("r3_a1_pen", {31'b0, PENABLE}, 1);
      chk("r3_a1_ready", {31'b0, ready}, 0);
      tick;
      PREADY3 = 1;
      #1;
      chk("r3_a2_ready", {31'b0, ready}, 1);
      chk("r3_a2_rdata", rdata, 32'hA5);
      tick;
      PREADY3 = 0;
      #1;
      chk("r3_i_psel", {27'b0, psel}, 0);
      chk("r3_i_ready", {31'b0, ready}, 0);
      chk("r3_i_rdata", rdata, 0);
      // read slot 1 with wait states and a stray PREADY0
      PREADY0 = 1; PRDATA0 = 32'hBAD0_0000; PREADY1 = 0; PRDATA1 = 32'h1234_5678;
      req(0, 32'h1000_1008, 0);
      #1;
      chk("r1_s_psel", {27'b0, psel}, 5'b00010);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk($sformatf("r1_w%0d_pen", i), {31'b0, PENABLE}, 1);
         chk($sformatf("r1_w%0d_ready", i), {31'b0, ready}, 0);
         chk($sformatf("r1_w%0d_paddr", i), PADDR, 32'h1000_1008);
      end
      tick;
      PREADY1 = 1;
      #1;
      chk("r1_ready", {31'b0, ready}, 1);
      chk("r1_rdata", rdata, 32'h1234_5678);
      tick;
      PREADY1 = 0;
      #1;
      chk("r1_i_psel", {27'b0, psel}, 0);
      // unmapped reads complete without any select
      {PREADY0, PREADY1, PREADY2, PREADY3, PREADY4} = '0;
      PRDATA2 = 32'h7777_7777; PRDATA4 = 32'h4444_4444;
      for (int k = 0; k < 3; k++) begin
         req(0, unm[k], 0);
         #1;
         chk($sformatf("un%0d_s_psel", k), {27'b0, psel}, 0);
         chk($sformatf("un%0d_s_ready", k), {31'b0, ready}, 0);
         tick;
         chk($sformatf("un%0d_a_psel", k), {27'b0, psel}, 0);
         chk($sformatf("un%0d_a_ready", k), {31'b0, ready}, 1);
         chk($sformatf("un%0d_a_rdata", k), rdata, 0);
         tick;
         chk($sformatf("un%0d_i_ready", k), {31'b0, ready}, 0);
      end
      // back-to-back: write slot 4 top word, then read slot 0
      PREADY4 = 1; PREADY0 = 1; PRDATA0 = 32'hCAFE_0000;
      req(1, 32'h1000_4FFC, 32'h1122_3344);
      #1;
      chk("bb1_s_psel", {27'b0, psel}, 5'b10000);
      chk("bb1_s_paddr", PADDR, 32'h1000_4FFC);
      tick;
      chk("bb1_a_ready", {31'b0, ready}, 1);
      chk("bb1_a_pwdata", PWDATA, 32'h1122_3344);
      tick;
      transfer = 1; write = 0; addr = 32'h1000_0010; wdata = 32'h5555_5555;
      #1;
      chk("bb_i_psel", {27'b0, psel}, 0);
      chk("bb_i_pen", {31'b0, PENABLE}, 0);
      chk("bb_i_ready", {31'b0, ready}, 0);
      chk("bb_i_paddr", PADDR, 32'h1000_4FFC);
      tick;
      transfer = 0; addr = 32'hDEAD_BEEF; wdata = 0;
      #1;
      chk("bb2_s_psel", {27'b0, psel}, 5'b00001);
      chk("bb2_s_paddr", PADDR, 32'h1000_0010);
      chk("bb2_s_pwdata", PWDATA, 32'h5555_5555);
      chk("bb2_s_pwrite", {31'b0, PWRITE}, 0);
      tick;
      chk("bb2_a_ready", {31'b0, ready}, 1);
      chk("bb2_a_rdata", rdata, 32'hCAFE_0000);
      tick;
      chk("bb2_i_psel", {27'b0, psel}, 0);
      // reset during ACCESS abandons the transfer
      PREADY0 = 0; PREADY4 = 0; PREADY2 = 0; PRDATA2 = 32'h0BAD_F00D;
      req(0, 32'h1000_2000, 0);
      tick;
      chk("rs_a_pen", {31'b0, PENABLE}, 1);
      #1;
      PRESET = 1;
      #1;
      all_zero("rs_async");
      PREADY2 = 1;
      tick;
      all_zero("rs_hold");
      PRESET = 0;
      tick;
      chk("rs_idle_ready", {31'b0, ready}, 0);
      req(0, 32'h1000_2000, 0);
      #1;
      chk("rs_s_psel", {27'b0, psel}, 5'b00100);
      tick;
      chk("rs_a_ready", {31'b0, ready}, 1);
      chk("rs_a_rdata", rdata, 32'h0BAD_F00D);
      tick;
      chk("rs_i_psel", {27'b0, psel}, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/apb_master.md
# apb_master

APB initiator bridging the RISC-V core's data-memory port to the peripheral bus. It converts a single-cycle CPU transfer request into a standard APB SETUP/ACCESS sequence. It decodes the address into one of five slave selects and multiplexes slave read data and ready back to the core. It sits between the CPU and the APB slaves: RAM, GPO, GPI, GPIO and FND.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000, base of the APB address window.
- SLOT_SHIFT, 12, log2 of the per-slave address slot size (4 KiB).

Ports:
- PCLK  in  1  system clock; all state updates on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- transfer  in  1  one-cycle CPU request pulse; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; qualified by transfer.
- addr  in  32  CPU byte address; qualified by transfer.
- wdata  in  32  CPU write data; qualified by transfer.
- rdata  out  32  read data returned to the CPU; valid when ready=1.
- ready  out  1  transfer-complete strobe to the CPU.
- PADDR  out  32  APB address (latched addr).
- PWDATA  out  32  APB write data (latched wdata).
- PWRITE  out  1  APB direction (latched write).
- PENABLE  out  1  APB enable.
- PSEL0..PSEL4  out  1 each  slave selects for slots 0..4.
- PRDATA0..PRDATA4  in  32 each  slave read data.
- PREADY0..PREADY4  in  1 each  slave ready.

## Operation
- Latch registers addr_r, wdata_r, write_r:
  - Loaded only when state=IDLE and transfer=1.
  - Drive PADDR, PWDATA and PWRITE directly.
- Decode:
  - slot = (addr_r - BASE_ADDR) >> SLOT_SHIFT.
  - Valid when addr_r is in [BASE_ADDR, BASE_ADDR + 5<<SLOT_SHIFT).
  - sel_vec is one-hot over the 5 slots; it is all-zero when the address is unmapped.
- PSELn = sel_vec[n] & (state ≠ IDLE). PENABLE = (state == ACCESS).
- Mux:
  - Selected slave → (PRDATAn, PREADYn).
  - Unmapped address → PRDATA = 0, PREADY = 1, so an unmapped access completes instead of hanging.
  - PREADY from non-selected slaves is ignored.
- FSM has three states:
  - IDLE: transfer=1 → SETUP; otherwise stay.
  - SETUP: unconditionally → ACCESS.
  - ACCESS: muxed PREADY=1 → IDLE; otherwise stay (wait states, unbounded).
- ready = (state==ACCESS) & muxed PREADY. This is combinational, and it pulses for exactly one cycle per transfer.
- rdata = muxed PRDATA when ready=1 and write_r=0; otherwise 0.
- A transfer pulse in SETUP or ACCESS is ignored. The CPU must not issue a new request until it has seen ready.
- Back-to-back requests: a transfer in the cycle after ready (state IDLE) is accepted normally. There is no SETUP skip.

## Timing
- Reset values:
  - state = IDLE.
  - addr_r, wdata_r, write_r = 0.
  - Therefore PADDR = 0, PWDATA = 0, PWRITE = 0, PENABLE = 0, all PSELn = 0, ready = 0, rdata = 0.
- Cycle 0: transfer=1 sampled at the edge.
- Cycle 1: SETUP; PSEL=1, PENABLE=0, with address, data and direction stable.
- Cycle 2: ACCESS; PENABLE=1.
  - Zero-wait slave: ready=1 in cycle 2.
  - Registered-PREADY slave (asserts PREADY one cycle after PSEL&PENABLE): ready=1 in cycle 3.
- Minimum transfer latency is 2 cycles from the request edge to ready. Each wait state adds 1 cycle.
- PADDR, PWDATA and PWRITE are held constant from SETUP through the final ACCESS cycle.
- PSEL and PENABLE drop in the cycle after ready.
- Reset asserted mid-transfer:
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight transfer is abandoned; no ready is issued.

## Test plan
- Write 0x0000_00FF to 0x1000_3000 (slot 3), zero-wait slave:
  - PSEL3=1/PENABLE=0 in cycle 1, PENABLE=1 in cycle 2.
  - PWRITE=1, PWDATA=0xFF; ready=1 in cycle 2 only.
  - Other PSELs stay 0.
- Read 0x1000_3004, slave with registered PREADY, PRDATA3=0xA5:
  - ACCESS lasts 2 cycles.
  - ready=1 and rdata=0x0000_00A5 in cycle 3; PSEL3 drops in cycle 4.
- Read 0x1000_1008 with PREADY1 held low for 4 cycles while PREADY0=1:
  - Remains in ACCESS and PADDR stays stable.
  - ready only when PREADY1 rises; the stray PREADY0 is ignored.
- Read unmapped 0x2000_0000:
  - No PSEL asserted; ready=1 in cycle 2, rdata=0.
- Back-to-back: write to slot 4 immediately followed by a read of slot 0 on the cycle after ready:
  - Two complete SETUP/ACCESS sequences.
  - No overlap; the second request's address and data are not corrupted.
- Assert PRESET during ACCESS:
  - All outputs go to 0 asynchronously; ready never pulses.
  - A new transfer after reset release completes normally.
